// File: rtl/mpq_pkg.sv
// Shared definitions for the MPQ command scheduler.
// Holds the opcode encodings, the issue FSM state type, the default data
// width and a helper that classifies an opcode as legal.
package mpq_pkg;

  localparam int MPQ_DW = 8;

  localparam logic [2:0] OP_BUILD   = 3'b000;
  localparam logic [2:0] OP_EXTRACT = 3'b001;
  localparam logic [2:0] OP_INCR    = 3'b010;
  localparam logic [2:0] OP_INSERT  = 3'b011;
  localparam logic [2:0] OP_WRITE   = 3'b100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Opcodes 101..111 are reserved and must never reach the core.
  function automatic logic op_legal(input logic [2:0] op);
    logic ok;
    case (op)
      OP_BUILD, OP_EXTRACT, OP_INCR, OP_INSERT, OP_WRITE: ok = 1'b1;
      default:                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mpq_cmd_fifo.sv
// Synchronous command FIFO for the MPQ scheduler.
// Pointers carry one extra MSB so full and empty are distinguishable
// without a separate flag; the occupancy count is their difference.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata     write strobe and entry (ignored when full)
//   pop             read strobe (ignored when empty)
//   rdata           head entry, valid whenever empty is low
//   full, empty     status flags
//   count           number of stored entries, 0..DEPTH
module mpq_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_r [DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         do_push_s;
  logic         do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance; a reset discards all stored entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mpq_cmd_sched.sv
// Command scheduler between the host stimulus port and the MPQ core.
// Host commands are queued in a FIFO and issued one at a time, waiting for
// the core's busy handshake between issues. Initial data words are
// forwarded while in the load phase. A write-out command ends the session:
// once the core reports completion a single done pulse is raised and the
// block parks with all core outputs at zero until reset.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   data_valid, data            host data stream (load phase only)
//   cmd_valid, cmd, index, value host command and operands
//   busy                        backpressure, leaves one skid slot
//   core_data_valid, core_data  registered data to the core
//   core_cmd_valid              one-cycle issue pulse
//   core_cmd, core_index, core_value  issued command, held after the pulse
//   core_busy, core_done        core handshake inputs
//   done                        one-cycle completion pulse
//   err                         sticky: dropped command or late data
module mpq_cmd_sched
  import mpq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = MPQ_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic [DW-1:0] index,
  input  logic [DW-1:0] value,
  output logic          busy,
  output logic          core_data_valid,
  output logic [DW-1:0] core_data,
  output logic          core_cmd_valid,
  output logic [2:0]    core_cmd,
  output logic [DW-1:0] core_index,
  output logic [DW-1:0] core_value,
  input  logic          core_busy,
  input  logic          core_done,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 3 + 2 * DW;
  localparam logic [CW-1:0] BUSY_LEVEL = CW'(DEPTH - 1);

  state_e        state_r;
  state_e        state_s;
  logic          phase_run_r;
  logic          wr_seen_r;
  logic          err_r;
  logic          done_r;
  logic          core_data_valid_r;
  logic [DW-1:0] core_data_r;
  logic          core_cmd_valid_r;
  logic [2:0]    core_cmd_r;
  logic [DW-1:0] core_index_r;
  logic [DW-1:0] core_value_r;

  logic          push_s;
  logic          drop_s;
  logic          late_data_s;
  logic          pop_s;
  logic          done_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [FW-1:0] head_s;

  // Once write-out is queued the session is closed to further commands.
  assign push_s      = cmd_valid && op_legal(cmd) && !full_s && !wr_seen_r;
  assign drop_s      = cmd_valid && !push_s;
  assign late_data_s = data_valid && phase_run_r;

  // Threshold at DEPTH-1: the host reacts a cycle late, so one slot is kept spare.
  assign busy = (count_s >= BUSY_LEVEL) || (state_r == FIN);

  mpq_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .wdata ({cmd, index, value}),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue FSM next state, pop and completion strobes.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !core_busy) begin
          pop_s   = 1'b1;
          state_s = ACK;
        end else begin
          state_s = IDLE;
        end
      end
      // Blank cycle so the core has time to raise core_busy.
      ACK: begin
        if (core_cmd_r == OP_WRITE) begin
          state_s = FLUSH;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (!core_busy) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      FLUSH: begin
        if (core_done) begin
          done_s  = 1'b1;
          state_s = FIN;
        end else begin
          state_s = FLUSH;
        end
      end
      FIN: begin
        state_s = FIN;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Command outputs: load on issue, hold afterwards, clear when the session ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_cmd_valid_r <= 1'b0;
      core_cmd_r       <= 3'b000;
      core_index_r     <= {DW{1'b0}};
      core_value_r     <= {DW{1'b0}};
      done_r           <= 1'b0;
    end else begin
      core_cmd_valid_r <= pop_s;
      done_r           <= done_s;
      if (done_s) begin
        core_cmd_r   <= 3'b000;
        core_index_r <= {DW{1'b0}};
        core_value_r <= {DW{1'b0}};
      end else if (pop_s) begin
        core_cmd_r   <= head_s[FW-1 -: 3];
        core_index_r <= head_s[2*DW-1 -: DW];
        core_value_r <= head_s[DW-1:0];
      end
    end
  end

  // Data forwarding during load; zeroed once the session has finished.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_data_valid_r <= 1'b0;
      core_data_r       <= {DW{1'b0}};
    end else if (done_s || (state_r == FIN)) begin
      core_data_valid_r <= 1'b0;
      core_data_r       <= {DW{1'b0}};
    end else if (!phase_run_r) begin
      core_data_valid_r <= data_valid;
      core_data_r       <= data;
    end else begin
      core_data_valid_r <= 1'b0;
    end
  end

  // Phase, write-out-seen and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_run_r <= 1'b0;
      wr_seen_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (push_s) begin
        phase_run_r <= 1'b1;
      end
      if (push_s && (cmd == OP_WRITE)) begin
        wr_seen_r <= 1'b1;
      end
      if (drop_s || late_data_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign core_data_valid = core_data_valid_r;
  assign core_data       = core_data_r;
  assign core_cmd_valid  = core_cmd_valid_r;
  assign core_cmd        = core_cmd_r;
  assign core_index      = core_index_r;
  assign core_value      = core_value_r;
  assign done            = done_r;
  assign err             = err_r;

endmodule

// File: tb/tb_mpq_cmd_sched.sv
// Scoreboard bench for mpq_cmd_sched. Stimulus pushes expected core-side
// transactions into queues; a negedge monitor pops and compares them when
// the DUT presents core_data_valid, core_cmd_valid or done.
module tb_mpq_cmd_sched;
  import mpq_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
    int            cyc;
  } cmd_exp_t;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } data_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = 3'b000;
  logic [DW-1:0] index = '0;
  logic [DW-1:0] value = '0;
  logic          busy;
  logic          core_data_valid;
  logic [DW-1:0] core_data;
  logic          core_cmd_valid;
  logic [2:0]    core_cmd;
  logic [DW-1:0] core_index;
  logic [DW-1:0] core_value;
  logic          core_busy;
  logic          core_done = 1'b0;
  logic          done;
  logic          err;

  logic          core_hold = 1'b0;
  int            busy_cnt = 0;
  int            cyc = 0;
  logic          prev_core_busy = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;

  cmd_exp_t      exp_cmd[$];
  data_exp_t     exp_data[$];
  int            exp_done[$];

  mpq_cmd_sched #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_valid      (data_valid),
    .data            (data),
    .cmd_valid       (cmd_valid),
    .cmd             (cmd),
    .index           (index),
    .value           (value),
    .busy            (busy),
    .core_data_valid (core_data_valid),
    .core_data       (core_data),
    .core_cmd_valid  (core_cmd_valid),
    .core_cmd        (core_cmd),
    .core_index      (core_index),
    .core_value      (core_value),
    .core_busy       (core_busy),
    .core_done       (core_done),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: busy for 5 cycles after each issue, or forced by core_hold.
  always @(posedge clk or negedge rst) begin
    if (!rst)                busy_cnt <= 0;
    else if (core_cmd_valid) busy_cnt <= 5;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  end
  assign core_busy = core_hold | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every presented core-side transaction with the scoreboard.
  always @(negedge clk) begin
    if (core_data_valid) begin
      if (exp_data.size() == 0) check("data_unexpected", {31'd0, core_data_valid}, 32'd0);
      else begin
        check("core_data", {24'd0, core_data}, {24'd0, exp_data[0].d});
        if (exp_data[0].cyc >= 0) check("data_latency", cyc, exp_data[0].cyc);
        void'(exp_data.pop_front());
      end
    end
    if (core_cmd_valid) begin
      if (exp_cmd.size() == 0) check("issue_unexpected", {31'd0, core_cmd_valid}, 32'd0);
      else begin
        check("issue_operands", {13'd0, core_cmd, core_index, core_value},
              {13'd0, exp_cmd[0].op, exp_cmd[0].idx, exp_cmd[0].val});
        if (exp_cmd[0].cyc >= 0) check("issue_cycle", cyc, exp_cmd[0].cyc);
        check("issue_core_idle", {31'd0, prev_core_busy}, 32'd0);
        void'(exp_cmd.pop_front());
      end
    end
    if (done) begin
      if (exp_done.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
      else begin
        check("done_cycle", cyc, exp_done[0]);
        void'(exp_done.pop_front());
      end
    end
    prev_core_busy <= core_busy;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once, before any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    data_valid = 1'b0;
    cmd_valid = 1'b0;
    core_hold = 1'b0;
    core_done = 1'b0;
    #1;
    check("reset_outputs",
          {8'd0, busy, core_data_valid, core_data, core_cmd_valid, core_cmd, done, err},
          32'd0);
    check("reset_operands", {16'd0, core_index, core_value}, 32'd0);
    exp_cmd.delete();
    exp_data.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drive one command for one cycle; issued=1 queues the expected issue.
  task automatic send(input logic [2:0] op, input logic [DW-1:0] idx,
                      input logic [DW-1:0] val, input bit issued, input int exp_cyc);
    cmd_valid = 1'b1;
    cmd = op;
    index = idx;
    value = val;
    if (issued) exp_cmd.push_back('{op, idx, val, exp_cyc});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    data_valid = 1'b1;
    data = d;
    exp_data.push_back('{d, cyc + 1});
    step();
    data_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_data.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (exp_cmd.size() != 0 || exp_data.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d transactions outstanding, required 0",
               exp_cmd.size() + exp_data.size());
    end
  endtask

  initial begin
    #2;
    // Data stream then build: data 1 cycle late, build issued 1 cycle after push.
    do_reset();
    for (int i = 0; i < 12; i++) send_data(8'h10 + 8'(i));
    send(OP_BUILD, 8'h00, 8'h00, 1'b1, cyc + 2);
    wait_drain(40);
    check("err_after_load", {31'd0, err}, 32'd0);

    // Fill with the core held busy: busy rises at count 7, 8th accepted, 9th dropped.
    do_reset();
    core_hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("busy_fill", {31'd0, busy}, (i >= 7) ? 32'd1 : 32'd0);
      send(OP_INSERT, 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b1, -1);
    end
    check("err_before_overflow", {31'd0, err}, 32'd0);
    send(OP_INSERT, 8'h99, 8'h99, 1'b0, -1);
    check("err_overflow", {31'd0, err}, 32'd1);
    check("busy_full", {31'd0, busy}, 32'd1);
    core_hold = 1'b0;
    wait_drain(200);
    repeat (12) step();

    // Insert then increase-key: second issue 8 cycles after the first.
    do_reset();
    send(OP_INSERT, 8'h03, 8'h7F, 1'b1, cyc + 2);
    send(OP_INCR,   8'h02, 8'h90, 1'b1, cyc + 9);
    wait_drain(40);
    check("err_before_late_data", {31'd0, err}, 32'd0);
    data_valid = 1'b1;
    data = 8'h77;
    step();
    data_valid = 1'b0;
    step();
    check("err_late_data", {31'd0, err}, 32'd1);

    // Illegal opcode, then simultaneous push/pop at count 4.
    do_reset();
    core_hold = 1'b1;
    send(OP_INSERT, 8'h40, 8'h50, 1'b1, -1);
    send(OP_INSERT, 8'h41, 8'h51, 1'b1, -1);
    check("err_before_illegal", {31'd0, err}, 32'd0);
    send(3'b110, 8'hEE, 8'hEE, 1'b0, -1);
    check("err_illegal", {31'd0, err}, 32'd1);
    send(OP_INSERT, 8'h42, 8'h52, 1'b1, -1);
    send(OP_INSERT, 8'h43, 8'h53, 1'b1, -1);
    check("busy_count4", {31'd0, busy}, 32'd0);
    core_hold = 1'b0;
    send(OP_INSERT, 8'h44, 8'h54, 1'b1, -1);
    core_hold = 1'b1;
    send(OP_INSERT, 8'h45, 8'h55, 1'b1, -1);
    send(OP_INSERT, 8'h46, 8'h56, 1'b1, -1);
    check("busy_count6", {31'd0, busy}, 32'd0);
    send(OP_INSERT, 8'h47, 8'h57, 1'b1, -1);
    check("busy_count7", {31'd0, busy}, 32'd1);
    core_hold = 1'b0;
    wait_drain(200);
    repeat (12) step();

    // Write-out: done one cycle after core_done, then everything parked at zero.
    do_reset();
    send_data(8'h5A);
    send(OP_BUILD, 8'h00, 8'h00, 1'b1, -1);
    send(OP_WRITE, 8'h07, 8'h09, 1'b1, -1);
    wait_drain(60);
    repeat (13) step();
    core_done = 1'b1;
    exp_done.push_back(cyc + 1);
    repeat (4) step();
    core_done = 1'b0;
    check("busy_fin", {31'd0, busy}, 32'd1);
    check("fin_outputs_zero",
          {12'd0, core_cmd_valid, core_cmd, core_index, core_value},
          32'd0);
    check("fin_data_zero", {23'd0, core_data_valid, core_data}, 32'd0);
    check("err_before_late_cmd", {31'd0, err}, 32'd0);
    send(OP_INSERT, 8'h01, 8'h01, 1'b0, -1);
    repeat (3) step();
    check("err_late_cmd", {31'd0, err}, 32'd1);
    check("done_pending", exp_done.size(), 32'd0);

    // Reset in FLUSH, then restart from the load phase.
    do_reset();
    send(OP_WRITE, 8'h11, 8'h22, 1'b1, cyc + 2);
    wait_drain(20);
    repeat (3) step();
    do_reset();
    send_data(8'h33);
    send(OP_EXTRACT, 8'h05, 8'h06, 1'b1, cyc + 2);
    wait_drain(20);

    // Reset while an issue pulse is in flight.
    do_reset();
    send(OP_INCR, 8'h0A, 8'h0B, 1'b0, -1);
    step();
    check("pulse_inflight", {31'd0, core_cmd_valid}, 32'd1);
    do_reset();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
